// File: rtl/mips16_pkg.sv
// mips16_pkg: shared definitions for the 16-bit MIPS multi-cycle control path.
// Holds the opcode map, the control FSM state enum, the ALU-op and ALU
// B-source encodings, the decoded control word, and opcode helpers.
package mips16_pkg;

  // Opcodes, IR[15:12]
  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_ADDI = 4'b0100;
  localparam logic [3:0] OP_LW   = 4'b0101;
  localparam logic [3:0] OP_SW   = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_BEQ  = 4'b1000;
  localparam logic [3:0] OP_BNE  = 4'b1001;

  // ALU op encodings, shared with the ALU
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // ALU B-input select
  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_TWO    = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  typedef enum logic [3:0] {
    ST_FETCH, ST_DECODE, ST_MEMADR, ST_MEMRD, ST_MEMWB,
    ST_MEMWR, ST_EXEC, ST_RWB, ST_BRANCH, ST_HALT
  } state_e;

  // Coarse opcode class used to steer DECODE
  typedef enum logic [1:0] { CLS_MEM, CLS_ALU, CLS_BR, CLS_ILL } op_cls_e;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       i_or_d;
    logic       ir_write;
    logic       pc_write;
    logic       pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_ctrl;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       instr_done;
  } ctrl_t;

  function automatic op_cls_e op_class(input logic [3:0] op);
    case (op)
      OP_LW, OP_SW:                                       return CLS_MEM;
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_ADDI:     return CLS_ALU;
      OP_BEQ, OP_BNE:                                     return CLS_BR;
      default:                                            return CLS_ILL;
    endcase
  endfunction

  // ALU op for an R-type opcode (ADD for anything else)
  function automatic logic [2:0] rtype_alu(input logic [3:0] op);
    case (op)
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      OP_SLT:  return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: handshake to the single shared memory.
//   mem_req   - access request, held until mem_ready
//   mem_we    - access is a write
//   i_or_d    - address select: 0 = PC, 1 = ALUOut
//   mem_ready - memory completed the current request
// master: control FSM side. slave: memory side.
interface multicycle_ctrl_if;
  logic mem_req;
  logic mem_we;
  logic i_or_d;
  logic mem_ready;

  modport master (output mem_req, output mem_we, output i_or_d, input mem_ready);
  modport slave  (input mem_req, input mem_we, input i_or_d, output mem_ready);
endinterface

// File: rtl/multicycle_ctrl_out_decode.sv
// mctrl_out_decode: combinational state + opcode -> control word.
// Ports:
//   reset     in  forces every strobe low while high
//   state     in  current FSM state
//   opcode    in  IR[15:12]
//   alu_zero  in  ALU zero flag (branch resolution)
//   mem_ready in  memory handshake (gates fetch writes and MEMWR completion)
//   ctrl      out decoded control word
module mctrl_out_decode
  import mips16_pkg::*;
(
  input  logic       reset,
  input  state_e     state,
  input  logic [3:0] opcode,
  input  logic       alu_zero,
  input  logic       mem_ready,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl          = '0;
    ctrl.alu_ctrl = ALU_ADD;
    case (state)
      ST_FETCH: begin
        ctrl.mem_req   = 1'b1;
        ctrl.alu_src_b = SRCB_TWO;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;   // pc_src stays 0: PC <= PC + 2
      end
      ST_DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SH; // branch target into ALUOut
      end
      ST_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      ST_MEMRD: begin
        ctrl.mem_req = 1'b1;
        ctrl.i_or_d  = 1'b1;
      end
      ST_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      ST_MEMWR: begin
        ctrl.mem_req    = 1'b1;
        ctrl.mem_we     = 1'b1;
        ctrl.i_or_d     = 1'b1;
        ctrl.instr_done = mem_ready;
      end
      ST_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        if (opcode == OP_ADDI) begin
          ctrl.alu_src_b = SRCB_IMM;
        end else begin
          ctrl.alu_src_b = SRCB_REG;
          ctrl.alu_ctrl  = rtype_alu(opcode);
        end
      end
      ST_RWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = (opcode != OP_ADDI);
        ctrl.instr_done = 1'b1;
      end
      ST_BRANCH: begin
        ctrl.alu_src_a  = 1'b1;
        ctrl.alu_src_b  = SRCB_REG;
        ctrl.alu_ctrl   = ALU_SUB;
        ctrl.pc_src     = 1'b1;
        ctrl.pc_write   = (opcode == OP_BEQ) ? alu_zero : ~alu_zero;
        ctrl.instr_done = 1'b1;
      end
      default: ;  // HALT: everything idle
    endcase

    // Strobes must drop in the same cycle reset rises, whatever the state
    if (reset) begin
      ctrl.mem_req    = 1'b0;
      ctrl.mem_we     = 1'b0;
      ctrl.ir_write   = 1'b0;
      ctrl.pc_write   = 1'b0;
      ctrl.reg_write  = 1'b0;
      ctrl.instr_done = 1'b0;
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: control FSM for the multi-cycle 16-bit MIPS datapath.
// Sequences fetch/decode/execute/memory/writeback over a shared memory,
// one ALU, IR, PC and the register file, and counts retired instructions.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   opcode              IR[15:12]
//   alu_zero            ALU zero flag
//   mem                 memory handshake (multicycle_ctrl_if.master)
//   ir_write..reg_write datapath control strobes/selects
//   instr_done          pulse on the last cycle of each instruction
//   retired             completed-instruction count (wraps)
//   halted              FSM parked in HALT
// Build option: MCTRL_ILLEGAL_HALT_EN - illegal opcode parks the FSM in HALT
// until reset; otherwise an illegal opcode is a NOP and halted is tied 0.
module multicycle_ctrl
  import mips16_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [3:0]           opcode,
  input  logic                 alu_zero,
  multicycle_ctrl_if.master    mem,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic                 pc_src,
  output logic                 alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [2:0]           alu_ctrl,
  output logic                 reg_dst,
  output logic                 mem_to_reg,
  output logic                 reg_write,
  output logic                 instr_done,
  output logic [CNT_W-1:0]     retired,
  output logic                 halted
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  ctrl_t            ctrl;

  mctrl_out_decode u_dec (
    .reset     (reset),
    .state     (state_q),
    .opcode    (opcode),
    .alu_zero  (alu_zero),
    .mem_ready (mem.mem_ready),
    .ctrl      (ctrl)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH:  if (mem.mem_ready) state_d = ST_DECODE;
      ST_DECODE: begin
        case (op_class(opcode))
          CLS_MEM: state_d = ST_MEMADR;
          CLS_ALU: state_d = ST_EXEC;
          CLS_BR:  state_d = ST_BRANCH;
          default: begin
`ifdef MCTRL_ILLEGAL_HALT_EN
            state_d = ST_HALT;
`else
            state_d = ST_FETCH;
`endif
          end
        endcase
      end
      ST_MEMADR: state_d = (opcode == OP_SW) ? ST_MEMWR : ST_MEMRD;
      ST_MEMRD:  if (mem.mem_ready) state_d = ST_MEMWB;
      ST_MEMWR:  if (mem.mem_ready) state_d = ST_FETCH;
      ST_EXEC:   state_d = ST_RWB;
      ST_MEMWB, ST_RWB, ST_BRANCH: state_d = ST_FETCH;
      ST_HALT:   state_d = ST_HALT;
      default:   state_d = ST_FETCH;
    endcase

    retired_d = retired_q + CNT_W'(ctrl.instr_done);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_FETCH;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  assign mem.mem_req = ctrl.mem_req;
  assign mem.mem_we  = ctrl.mem_we;
  assign mem.i_or_d  = ctrl.i_or_d;
  assign ir_write    = ctrl.ir_write;
  assign pc_write    = ctrl.pc_write;
  assign pc_src      = ctrl.pc_src;
  assign alu_src_a   = ctrl.alu_src_a;
  assign alu_src_b   = ctrl.alu_src_b;
  assign alu_ctrl    = ctrl.alu_ctrl;
  assign reg_dst     = ctrl.reg_dst;
  assign mem_to_reg  = ctrl.mem_to_reg;
  assign reg_write   = ctrl.reg_write;
  assign instr_done  = ctrl.instr_done;
  assign retired     = retired_q;

`ifdef MCTRL_ILLEGAL_HALT_EN
  assign halted = (state_q == ST_HALT);
`else
  assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: randomized program with random memory wait states and
// branch flags. Expected per-instruction totals (cycles, request cycles,
// strobe counts, writeback selects, ALU setup) are computed from the
// instruction timing rules and queued; a monitor accumulates what the DUT
// does and compares on every instr_done. Directed phases cover reset,
// reset during a store, and illegal opcodes.
module tb_multicycle_ctrl;

  localparam int N_INSTR = 200;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  opcode;
  logic        alu_zero;
  logic        ir_write, pc_write, pc_src, alu_src_a, reg_dst, mem_to_reg;
  logic        reg_write, instr_done, halted;
  logic [1:0]  alu_src_b;
  logic [2:0]  alu_ctrl;
  logic [15:0] retired;

  multicycle_ctrl_if mif ();

  multicycle_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .alu_zero(alu_zero), .mem(mif),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .instr_done(instr_done), .retired(retired), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] op;
    int         fw;
    int         dw;
    logic       z;
  } instr_t;

  typedef struct {
    int         cyc, mreq, nir, npc, npcs, nwe, nrw;
    logic       rdst, m2r;
    int         alu_mode;   // 0 none, 1 cycle before done, 2 done cycle
    logic [2:0] alu;
    logic [1:0] srcb;
    int         ret;
  } exp_t;

  instr_t prog [N_INSTR+1];
  exp_t   exp_q [$];
  int     tests = 0, fails = 0;
  bit     run_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- program + reference model ----------------
  task automatic build_program();
    logic [3:0] legal [10];
    exp_t e, acc;
    int n_ret;
    logic taken;
    legal = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h7, 4'h4, 4'h5, 4'h6, 4'h8, 4'h9};
    acc = '{default: 0};
    n_ret = 0;
    for (int i = 0; i < N_INSTR; i++) begin
      int r;
`ifdef MCTRL_ILLEGAL_HALT_EN
      r = $urandom_range(0, 9);
`else
      r = (i == N_INSTR-1) ? $urandom_range(0, 9) : $urandom_range(0, 11);
`endif
      prog[i].op = (r < 10) ? legal[r] : 4'(4'hA + $urandom_range(0, 5));
      prog[i].fw = $urandom_range(0, 3);
      prog[i].dw = $urandom_range(0, 3);
      prog[i].z  = 1'($urandom_range(0, 1));

      // fetch: one cycle plus waits, PC += 2 and IR load once
      acc.cyc  += prog[i].fw + 1;
      acc.mreq += prog[i].fw + 1;
      acc.nir  += 1;
      acc.npc  += 1;
      e = acc;
      case (prog[i].op)
        4'h5: begin // LW: decode, address, read(+waits), writeback
          e.cyc += 3 + prog[i].dw + 1; e.mreq += prog[i].dw + 1;
          e.nrw = 1; e.rdst = 0; e.m2r = 1;
        end
        4'h6: begin // SW: decode, address, write(+waits)
          e.cyc += 2 + prog[i].dw + 1; e.mreq += prog[i].dw + 1;
          e.nwe = prog[i].dw + 1;
        end
        4'h0, 4'h1, 4'h2, 4'h3, 4'h7, 4'h4: begin // R-type / ADDI
          e.cyc += 3; e.nrw = 1; e.m2r = 0;
          e.rdst = (prog[i].op != 4'h4);
          e.alu_mode = 1;
          e.srcb = (prog[i].op == 4'h4) ? 2'b10 : 2'b00;
          case (prog[i].op)
            4'h1:    e.alu = 3'b110;
            4'h2:    e.alu = 3'b000;
            4'h3:    e.alu = 3'b001;
            4'h7:    e.alu = 3'b111;
            default: e.alu = 3'b010;
          endcase
        end
        4'h8, 4'h9: begin // branch: decode, compare
          taken = (prog[i].op == 4'h8) ? prog[i].z : ~prog[i].z;
          e.cyc += 2; e.npc += int'(taken); e.npcs = int'(taken);
          e.alu_mode = 2; e.alu = 3'b110; e.srcb = 2'b00;
        end
        default: begin // illegal: decode cycle folds into the next instruction
          acc.cyc += 1;
          continue;
        end
      endcase
      e.ret = n_ret;
      exp_q.push_back(e);
      n_ret++;
      acc = '{default: 0};
    end
    prog[N_INSTR] = '{op: 4'h0, fw: 100000, dw: 0, z: 1'b0}; // never completes
  endtask

  // ---------------- driver: IR and memory responder ----------------
  initial begin
    int  fetch_idx = 0, ir_idx = 0, wl = 0;
    bit  in_req = 0, load_pending = 0;
    forever begin
      @(negedge clk);
      if (run_en) begin
        if (load_pending) begin
          ir_idx   = fetch_idx;
          opcode   = prog[ir_idx].op;
          alu_zero = prog[ir_idx].z;
          fetch_idx++;
          load_pending = 0;
        end
        if (mif.mem_req) begin
          if (!in_req) begin
            in_req = 1;
            wl = mif.i_or_d ? prog[ir_idx].dw : prog[fetch_idx].fw;
          end
          if (wl == 0) begin
            mif.mem_ready = 1'b1;
            in_req = 0;
            if (!mif.i_or_d) load_pending = 1;
          end else begin
            mif.mem_ready = 1'b0;
            wl--;
          end
        end else begin
          mif.mem_ready = 1'($urandom_range(0, 1)); // must be ignored
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    int cyc = 0, mreq = 0, nir = 0, npc = 0, npcs = 0, nwe = 0, nrw = 0;
    logic rdst = 0, m2r = 0, p_srca = 0;
    logic [1:0] p_srcb = 0;
    logic [2:0] p_alu = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (run_en) begin
        cyc++;
        if (mif.mem_req)          mreq++;
        if (ir_write)             nir++;
        if (pc_write)             npc++;
        if (pc_write && pc_src)   npcs++;
        if (mif.mem_we)           nwe++;
        if (reg_write) begin nrw++; rdst = reg_dst; m2r = mem_to_reg; end
        if (instr_done) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_done", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("cycles", cyc, e.cyc);
            chk("mem_req_cycles", mreq, e.mreq);
            chk("ir_write_count", nir, e.nir);
            chk("pc_write_count", npc, e.npc);
            chk("pc_src_writes", npcs, e.npcs);
            chk("mem_we_cycles", nwe, e.nwe);
            chk("reg_write_count", nrw, e.nrw);
            if (e.nrw != 0) begin
              chk("reg_dst", int'(rdst), int'(e.rdst));
              chk("mem_to_reg", int'(m2r), int'(e.m2r));
            end
            if (e.alu_mode == 1) begin
              chk("exec_src_a", int'(p_srca), 1);
              chk("exec_src_b", int'(p_srcb), int'(e.srcb));
              chk("exec_alu", int'(p_alu), int'(e.alu));
            end else if (e.alu_mode == 2) begin
              chk("br_src_a", int'(alu_src_a), 1);
              chk("br_src_b", int'(alu_src_b), int'(e.srcb));
              chk("br_alu", int'(alu_ctrl), int'(e.alu));
            end
            chk("retired", int'(retired), e.ret);
          end
          cyc = 0; mreq = 0; nir = 0; npc = 0; npcs = 0; nwe = 0; nrw = 0;
          rdst = 0; m2r = 0;
        end
        p_srca = alu_src_a; p_srcb = alu_src_b; p_alu = alu_ctrl;
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int n_exp;
    reset = 1'b1; opcode = 4'h0; alu_zero = 1'b0; mif.mem_ready = 1'b1;
    build_program();
    n_exp = exp_q.size();

    repeat (3) @(negedge clk);
    #2;
    chk("rst_strobes", int'({mif.mem_req, mif.mem_we, ir_write, pc_write,
                             reg_write, instr_done}), 0);
    chk("rst_retired", int'(retired), 0);
    chk("rst_halted", int'(halted), 0);

    @(negedge clk);
    reset = 1'b0; mif.mem_ready = 1'b0;
    #2;
    chk("first_fetch_req", int'(mif.mem_req), 1);
    chk("first_fetch_iord", int'(mif.i_or_d), 0);

    @(posedge clk);
    run_en = 1'b1;
    for (int c = 0; c < 40000 && exp_q.size() != 0; c++) @(posedge clk);
    chk("drain_timeout", exp_q.size(), 0);
    run_en = 1'b0;
    #1;
    chk("retired_total", int'(retired), n_exp);

    // Reset while a store waits on memory
    @(negedge clk); mif.mem_ready = 1'b1;                  // FETCH completes
    @(negedge clk); mif.mem_ready = 1'b0; opcode = 4'h6;   // DECODE
    @(negedge clk);                                         // MEMADR
    @(negedge clk); #2;                                     // MEMWR
    chk("sw_mem_we", int'(mif.mem_we), 1);
    reset = 1'b1; #1;
    chk("rst_mid_sw_we", int'(mif.mem_we), 0);
    chk("rst_mid_sw_req", int'(mif.mem_req), 0);
    @(negedge clk); reset = 1'b0; #2;
    chk("post_rst_fetch", int'(mif.mem_req && !mif.i_or_d && !mif.mem_we), 1);
    chk("post_rst_retired", int'(retired), 0);

    // Illegal opcode
    @(negedge clk); mif.mem_ready = 1'b1;                  // FETCH completes
    @(negedge clk); mif.mem_ready = 1'b0; opcode = 4'hF;   // DECODE
    #2;
    chk("illegal_no_done", int'(instr_done), 0);
    @(negedge clk); #2;
`ifdef MCTRL_ILLEGAL_HALT_EN
    for (int c = 0; c < 10; c++) begin
      chk("halted", int'(halted), 1);
      chk("halt_strobes", int'({mif.mem_req, ir_write, pc_write, reg_write, instr_done}), 0);
      @(negedge clk); mif.mem_ready = 1'($urandom_range(0, 1)); #2;
    end
    chk("halt_retired", int'(retired), 0);
`else
    chk("illegal_to_fetch", int'(mif.mem_req && !mif.i_or_d), 1);
    chk("illegal_halted", int'(halted), 0);
    chk("illegal_retired", int'(retired), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle control FSM for the 16-bit MIPS datapath. It sequences a single shared memory, one ALU, the IR, the PC and the 2-bit-addressed register file. Every instruction is split into fetch/decode/execute/memory/writeback steps, and each memory step waits on a ready handshake. It replaces the single-cycle `MainControl` decode in the multi-cycle CPU variant.

## Interface
Parameters:
- `CNT_W`, 16, width of the retired-instruction counter.

Ports:
- `clk`  in  1  clock. All state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `opcode`  in  4  IR[15:12], from the instruction register.
- `alu_zero`  in  1  ALU zero flag, combinational from the current ALU op.
- `mem_ready`  in  1  memory has completed the current `mem_req`.
- `mem_req`  out  1  memory access request.
- `mem_we`  out  1  the access is a write (SW).
- `i_or_d`  out  1  memory address select: 0 = PC, 1 = ALUOut register.
- `ir_write`  out  1  load IR from memory read data.
- `pc_write`  out  1  load the PC (unconditional or resolved branch).
- `pc_src`  out  1  PC source: 0 = ALU result, 1 = ALUOut register.
- `alu_src_a`  out  1  ALU A input: 0 = PC, 1 = register A.
- `alu_src_b`  out  2  ALU B input: 00 = register B, 01 = const 2, 10 = sign-extended imm8, 11 = sign-extended imm8 << 1.
- `alu_ctrl`  out  3  ALU op, same encoding as the ALU: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT.
- `reg_dst`  out  1  write-register select: 0 = rt (IR[9:8]), 1 = rd (IR[7:6]).
- `mem_to_reg`  out  1  write-data select: 0 = ALUOut, 1 = MDR.
- `reg_write`  out  1  register file write enable.
- `instr_done`  out  1  one-cycle pulse on the last cycle of each instruction.
- `retired`  out  CNT_W  count of completed instructions.
- `halted`  out  1  the FSM is in HALT. Present only with the macro; otherwise tied 0.

## Operation
Opcodes:
- R-type: ADD 0000, SUB 0001, AND 0010, OR 0011, SLT 0111.
- I-type: ADDI 0100, LW 0101, SW 0110, BEQ 1000, BNE 1001.
- Any other opcode is illegal.

States (4-bit encoding, in this order): FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, RWB, BRANCH, HALT.

- FETCH:
  - Outputs: `mem_req`=1, `i_or_d`=0, src_a=0, src_b=01, ADD.
  - While `mem_ready`=0: hold in FETCH, no writes.
  - On `mem_ready`=1: `ir_write`=1, `pc_write`=1, `pc_src`=0 (PC += 2); next state DECODE.
- DECODE:
  - Outputs: src_a=0, src_b=11, ADD (branch target into ALUOut).
  - Next state: LW/SW → MEMADR, R-type/ADDI → EXEC, BEQ/BNE → BRANCH, illegal → FETCH.
- MEMADR: src_a=1, src_b=10, ADD. LW → MEMRD, SW → MEMWR.
- MEMRD: `mem_req`=1, `i_or_d`=1. Hold until `mem_ready`, then → MEMWB.
- MEMWB: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=1, `instr_done`; → FETCH.
- MEMWR: `mem_req`=1, `mem_we`=1, `i_or_d`=1. Hold until `mem_ready`, then `instr_done`; → FETCH.
- EXEC:
  - src_a=1.
  - R-type: src_b=00, `alu_ctrl` from the opcode table above.
  - ADDI: src_b=10, ADD.
  - Next state RWB.
- RWB: `reg_write`=1, `mem_to_reg`=0. `reg_dst`=1 for R-type, 0 for ADDI. `instr_done`; → FETCH.
- BRANCH:
  - Outputs: src_a=1, src_b=00, SUB, `pc_src`=1.
  - `pc_write` = BEQ ? `alu_zero` : ~`alu_zero`.
  - `instr_done`; → FETCH.
- Opcode is read from IR in every state after FETCH. IR changes only under `ir_write`.
- Outputs are a Moore decode of the state plus the opcode. The only Mealy terms are `mem_ready` (gating `ir_write`/`pc_write`/exit) and `alu_zero`.
- Every strobe not listed for a state is 0. `alu_ctrl` defaults to ADD.
- `retired` increments on `instr_done` and wraps from 2^CNT_W−1 to 0. An illegal opcode does not increment it.

## Timing
- Cycles per instruction, with zero memory wait: LW 5, SW 4, R-type/ADDI 4, branch 3. Each memory wait cycle adds 1.
- `mem_req` stays high, with address select stable, until `mem_ready`. `mem_ready` while `mem_req`=0 is ignored.
- `reset` high at an edge: next state FETCH, `retired`=0, `halted`=0.
- While `reset` is high, every strobe is forced to 0: `mem_req`, `mem_we`, `ir_write`, `pc_write`, `reg_write`, `instr_done`. Reset mid-MEMWR therefore drops `mem_we` in the same cycle.
- The first fetch request is asserted in the cycle after `reset` falls.
- `reset` has priority over `mem_ready` and over the counter increment.

## Configuration
- Macro `MCTRL_ILLEGAL_HALT_EN`.
- Defined: an illegal opcode in DECODE → HALT. HALT drives all strobes 0 and `halted`=1, and is left only by reset.
- Undefined: an illegal opcode behaves as a NOP (DECODE → FETCH), and `halted` is constant 0.

## Structure
- Shared package `mips16_pkg`: opcode localparams, state enum, `alu_ctrl` and `alu_src_b` encodings.
- One sub-module, `mctrl_out_decode`: combinational state+opcode → control word. The FSM register and counter stay in the top.

## Test plan
- LW (IR 0x5100), `mem_ready` high every cycle → states F,D,MA,MR,WB. `reg_write`/`mem_to_reg`=1 in cycle 5; `retired` goes 0→1.
- FETCH with `mem_ready` low for 3 cycles → `mem_req` high for 4 cycles. `ir_write`/`pc_write` pulse exactly once, in the 4th.
- BEQ (0x8C04): `alu_zero`=0 → `pc_write`=0 in BRANCH. BNE (0x96FC) with `alu_zero`=0 → `pc_write`=1, `pc_src`=1.
- SUB (0x1640) → EXEC `alu_ctrl`=110, src_b=00, then RWB `reg_dst`=1. ADDI (0x4504) → src_b=10, `reg_dst`=0.
- `reset` asserted in MEMWR with `mem_ready`=0 → `mem_we`=0 in that cycle, FETCH next, `retired`=0.
- Opcode 0xF: with the macro, `halted`=1 and HALT holds for 10 cycles. Without it, FETCH follows DECODE and `retired` is unchanged.
